// File: rtl/pc_update_unit.sv
// rtl/pc_update_unit.sv - program-counter sequencer with jump/branch redirect, busywait hold and saturating counters
module pc_update_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             BUSYWAIT,
    input  logic             JUMP,
    input  logic             BRANCH,
    input  logic             ZERO,
    input  logic [31:0]      OFFSET,
    output logic [31:0]      PC,
    output logic [31:0]      PC_PLUS4,
    output logic             FETCH_VALID,
    output logic             REDIRECT,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] REDIR_CNT
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic [31:0] target;
    logic        taken;
    logic        stall_inc;
    logic        redir_inc;

    assign PC_PLUS4 = PC + 32'd4;
    assign target   = PC_PLUS4 + OFFSET;
    // JUMP and BRANCH share one target, so the OR already gives jump priority
    assign taken    = JUMP | (BRANCH & ZERO);

    always_comb begin
        state_next = state;
        pc_next    = PC;
        stall_inc  = 1'b0;
        redir_inc  = 1'b0;
        REDIRECT   = 1'b0;
        case (state)
            IDLE: begin
                state_next = RUN;
            end
            RUN, STALL: begin
                if (BUSYWAIT) begin
                    state_next = STALL;
                    stall_inc  = 1'b1;
                end else if (taken) begin
                    state_next = RUN;
                    pc_next    = target;
                    redir_inc  = 1'b1;
                    REDIRECT   = 1'b1;
                end else begin
                    state_next = RUN;
                    pc_next    = PC_PLUS4;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            PC          <= RESET_PC;
            FETCH_VALID <= 1'b0;
            STALL_CNT   <= '0;
            REDIR_CNT   <= '0;
        end else begin
            state <= state_next;
            PC    <= pc_next;
            if (state == IDLE) begin
                FETCH_VALID <= 1'b1;
            end
            if (stall_inc && (STALL_CNT != CNT_MAX)) begin
                STALL_CNT <= STALL_CNT + 1'b1;
            end
            if (redir_inc && (REDIR_CNT != CNT_MAX)) begin
                REDIR_CNT <= REDIR_CNT + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_update_unit.sv
// tb/tb_pc_update_unit.sv - directed and randomized check of pc_update_unit against a behavioural model
module tb_pc_update_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             BUSYWAIT = 1'b0;
    logic             JUMP = 1'b0;
    logic             BRANCH = 1'b0;
    logic             ZERO = 1'b0;
    logic [31:0]      OFFSET = 32'h0;
    logic [31:0]      PC;
    logic [31:0]      PC_PLUS4;
    logic             FETCH_VALID;
    logic             REDIRECT;
    logic [CNT_W-1:0] STALL_CNT;
    logic [CNT_W-1:0] REDIR_CNT;

    int checks   = 0;
    int failures = 0;

    // reference model: a PC, a "started" flag and two plain integer counters
    logic [31:0] m_pc      = 32'h0;
    bit          m_started = 1'b0;
    bit          m_fv      = 1'b0;
    int          m_sc      = 0;
    int          m_rc      = 0;

    pc_update_unit #(
        .RESET_PC(32'h0000_0000),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .BUSYWAIT   (BUSYWAIT),
        .JUMP       (JUMP),
        .BRANCH     (BRANCH),
        .ZERO       (ZERO),
        .OFFSET     (OFFSET),
        .PC         (PC),
        .PC_PLUS4   (PC_PLUS4),
        .FETCH_VALID(FETCH_VALID),
        .REDIRECT   (REDIRECT),
        .STALL_CNT  (STALL_CNT),
        .REDIR_CNT  (REDIR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // one clock: drive inputs, check combinational outputs, clock, check registered state
    task automatic cyc(input bit rst, input bit bw, input bit j, input bit b, input bit z,
                       input logic [31:0] off);
        bit tk;
        @(negedge CLK);
        RESET    = rst;
        BUSYWAIT = bw;
        JUMP     = j;
        BRANCH   = b;
        ZERO     = z;
        OFFSET   = off;
        #1;
        tk = j || (b && z);
        check("pc_plus4", PC_PLUS4, m_pc + 32'd4);
        check("redirect", {31'b0, REDIRECT}, {31'b0, tk && !bw && m_started});
        @(posedge CLK);
        if (rst) begin
            m_pc = 32'h0; m_started = 0; m_fv = 0; m_sc = 0; m_rc = 0;
        end else if (!m_started) begin
            m_started = 1; m_fv = 1;
        end else if (bw) begin
            if (m_sc < CNT_MAX) m_sc++;
        end else if (tk) begin
            m_pc = m_pc + 32'd4 + off;
            if (m_rc < CNT_MAX) m_rc++;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        #1;
        check("pc", PC, m_pc);
        check("fetch_valid", {31'b0, FETCH_VALID}, {31'b0, m_fv});
        check("stall_cnt", {28'b0, STALL_CNT}, 32'(m_sc));
        check("redir_cnt", {28'b0, REDIR_CNT}, 32'(m_rc));
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("reset_pc", PC, 32'h0);
        check("reset_fv", {31'b0, FETCH_VALID}, 32'h0);

        // release then sequential fetch: 0,4,8,12,16
        cyc(0, 0, 0, 0, 0, 0);
        check("first_fetch_pc", PC, 32'h0);
        check("first_fetch_fv", {31'b0, FETCH_VALID}, 32'h1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
        check("seq_pc", PC, 32'h10);

        cyc(0, 0, 0, 1, 1, 32'h8);
        check("branch_taken_pc", PC, 32'h1C);
        check("branch_taken_rc", {28'b0, REDIR_CNT}, 32'h1);
        cyc(0, 0, 0, 1, 0, 32'h8);
        check("branch_not_taken_pc", PC, 32'h20);
        check("branch_not_taken_rc", {28'b0, REDIR_CNT}, 32'h1);

        cyc(0, 0, 1, 0, 0, 32'h1C);
        check("jump_fwd_pc", PC, 32'h40);
        cyc(0, 0, 1, 0, 0, 32'hFFFF_FFE0);
        check("jump_back_pc", PC, 32'h24);
        cyc(0, 0, 1, 1, 0, 32'hFFFF_FFE0);
        check("jump_over_branch_pc", PC, 32'h8);

        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 32'hFFFF_FFFC);
        check("self_loop_pc", PC, 32'h8);

        cyc(0, 0, 1, 0, 0, 32'h14);
        check("to_0x20", PC, 32'h20);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 32'h10);
        check("stall_hold_pc", PC, 32'h20);
        check("stall_cnt3", {28'b0, STALL_CNT}, 32'h3);
        check("stall_fv", {31'b0, FETCH_VALID}, 32'h1);
        cyc(0, 0, 1, 0, 0, 32'h10);
        check("after_stall_pc", PC, 32'h34);

        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0, 0);
        check("stall_sat", {28'b0, STALL_CNT}, 32'hF);
        cyc(1, 1, 1, 0, 0, 32'h40);
        check("reset_mid_stall_pc", PC, 32'h0);
        check("reset_mid_stall_sc", {28'b0, STALL_CNT}, 32'h0);
        check("reset_mid_stall_fv", {31'b0, FETCH_VALID}, 32'h0);

        // busywait at release still leaves IDLE with PC at reset value
        cyc(0, 1, 1, 0, 0, 32'h40);
        check("release_bw_pc", PC, 32'h0);
        check("release_bw_fv", {31'b0, FETCH_VALID}, 32'h1);
        cyc(0, 0, 1, 0, 0, 32'hFFFF_FFF8);
        check("to_top_pc", PC, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0, 0);
        check("wrap_pc", PC, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            logic [31:0] off;
            int o;
            r = $urandom();
            o = int'($urandom_range(0, 64)) - 32;
            off = ($urandom_range(0, 7) == 0) ? {r[31:2], 2'b00} : 32'(o * 4);
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, off);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
